fetch_queue_unit: RTL and testbench
===================================

Name: fetch_queue_unit

Overview:
- Parametrised successor to the single-entry PC/fetch stage.
- Holds the fetch PC and issues requests to an external synchronous instruction memory with 1-cycle read latency.
- Buffers returned instructions with their PCs in a DEPTH-entry FIFO, and hands them to decode over a valid/ready handshake.
- A redirect (mispredict or exception) flushes the queue and any in-flight fetch, then restarts fetch at the redirect target.

Parameters:
- RESET_PC, 32'h8000_0000, fetch PC loaded on reset.
- DEPTH, 4, instruction queue entries; power of two, at least 2.
- XLEN, 32, PC and instruction width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high.
- redirect_valid  input  1  flush and restart fetch.
- redirect_pc  input  XLEN  restart target; bits [1:0] ignored and forced to 0.
- imem_req  output  1  fetch request this cycle.
- imem_addr  output  XLEN  fetch address; equals the current fetch PC.
- imem_rdata  input  XLEN  instruction; valid in the cycle after imem_req.
- out_valid  output  1  head entry available.
- out_ready  input  1  decode accepts the head entry.
- out_instr  output  XLEN  head instruction.
- out_pc  output  XLEN  PC of the head instruction.

Behaviour:
- Reset:
  - fetch_pc = RESET_PC; queue count = 0; rd_ptr = wr_ptr = 0; inflight = 0.
  - imem_req = 0, out_valid = 0.
  - out_instr and out_pc read the head entry; their values are don't-care while out_valid = 0.
  - Reset takes priority over every other input, including mid-fetch and mid-redirect.
- Request issue (combinational):
  - imem_req = !reset && !redirect_valid && (count + inflight < DEPTH).
  - The credit check ignores a same-cycle pop. This is conservative: the queue can never overflow.
- On each clock edge where imem_req = 1: fetch_pc += 4 (wraps modulo 2^XLEN), and inflight <= 1.
- When imem_req = 0 and no redirect: inflight <= 0.
- Response:
  - When inflight = 1 and there is no redirect this cycle, {imem_rdata, pc_of_request} is written at wr_ptr on the clock edge.
  - pc_of_request is the registered copy of imem_addr.
- Pop: out_valid = (count != 0) && !redirect_valid. A pop happens when out_valid && out_ready.
  - Push and pop in the same cycle leave count unchanged.
  - When the queue is full, the pop makes room; the credit rule guarantees no push arrives without space.
- Latency: the first request is in cycle 0 after reset deasserts. The entry is written at the end of cycle 1. out_valid = 1 in cycle 2.
- Steady state: one instruction per cycle when out_ready is held high.
- Redirect (redirect_valid = 1 in cycle N):
  - In cycle N: out_valid = 0, imem_req = 0.
  - At the edge ending cycle N: count <= 0, pointers <= 0, inflight <= 0 (the returning response is dropped), fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - Cycle N+1 requests the target; the target is visible on out_pc in cycle N+3.
- Back-to-back redirects: the last one wins. Each redirect cycle flushes again.
- out_ready is ignored while out_valid = 0.
- Pointer wrap is modulo DEPTH.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined, adds three outputs, each 32 bits, all reset to 0 and saturating at 32'hFFFF_FFFF:
  - perf_fetched: count of pop handshakes.
  - perf_redirects: count of cycles with redirect_valid = 1.
  - perf_full_stalls: count of cycles with !reset && !redirect_valid && imem_req = 0.
- When undefined, these ports and their counters do not exist. Core behaviour is identical in both builds.

Test Plan:
- Reset, then out_ready = 1 held, with memory returning addr ^ 32'hA5A5_0000 -> out_valid first high in cycle 2; out_pc sequence 8000_0000, 8000_0004, 8000_0008, one per cycle; out_instr matches.
- out_ready = 0 for 10 cycles, DEPTH = 4 -> exactly 4 requests issued (8000_0000..8000_000C); imem_req stays low after that; count = 4. Raise out_ready -> the 4 entries drain in order, then fetch resumes at 8000_0010 with no gap or duplicate.
- Redirect to 32'h8000_0103 while 3 entries are queued and 1 request is in flight -> out_valid = 0 in the redirect cycle; next request address = 8000_0100; out_pc = 8000_0100 three cycles after redirect; no stale instruction ever appears.
- Redirect in two consecutive cycles (targets 8000_0200, then 8000_0300) -> only the 8000_0300 stream appears.
- Assert reset while the queue is full and a request is in flight -> next cycle: out_valid = 0, imem_addr = 8000_0000; normal restart.
- FETCH_PERF_EN build: the first scenario for 20 cycles plus one redirect -> perf_fetched equals the observed handshake count; perf_redirects = 1; perf_full_stalls = 0 with out_ready held high.

Source files
------------

// File: rtl/fetch_queue_unit.sv
// Fetch PC, 1-cycle-latency imem request issue and DEPTH-entry instruction queue to decode.
// Optional performance counters are enabled by defining FETCH_PERF_EN.
module fetch_queue_unit #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
   parameter int              DEPTH    = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_instr,
   output logic [XLEN-1:0] out_pc
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]     perf_fetched,
   output logic [31:0]     perf_redirects,
   output logic [31:0]     perf_full_stalls
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] req_pc_q;
   logic            inflight_q;
   logic [CW-1:0]   count_q, count_d;
   logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
   logic [XLEN-1:0] instr_q [DEPTH];
   logic [XLEN-1:0] pc_q    [DEPTH];

   logic [CW:0]     used;
   logic            push, pop;

   // Credit counts the outstanding response but not a same-cycle pop, so a push always has room.
   assign used      = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
   assign imem_req  = !reset && !redirect_valid && (used < (CW+1)'(DEPTH));
   assign imem_addr = fetch_pc_q;

   assign out_valid = !reset && !redirect_valid && (count_q != '0);
   assign out_instr = instr_q[rd_ptr_q];
   assign out_pc    = pc_q[rd_ptr_q];

   assign push = !reset && !redirect_valid && inflight_q;
   assign pop  = out_valid && out_ready;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      count_d    = count_q;
      if (imem_req)
         fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (push && !pop)
         count_d = count_q + CW'(1);
      else if (pop && !push)
         count_d = count_q - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= '0;
         inflight_q <= 1'b0;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
      end else if (redirect_valid) begin
         // Drops queued entries and the response currently returning.
         fetch_pc_q <= {redirect_pc[XLEN-1:2], 2'b00};
         inflight_q <= 1'b0;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         inflight_q <= imem_req;
         count_q    <= count_d;
         if (imem_req)
            req_pc_q <= fetch_pc_q;
         if (push)
            wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)
            rd_ptr_q <= rd_ptr_q + AW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         instr_q[wr_ptr_q] <= imem_rdata;
         pc_q[wr_ptr_q]    <= req_pc_q;
      end
   end

`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched_q, perf_redirects_q, perf_full_stalls_q;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         perf_fetched_q     <= '0;
         perf_redirects_q   <= '0;
         perf_full_stalls_q <= '0;
      end else begin
         if (pop)
            perf_fetched_q <= sat_inc(perf_fetched_q);
         if (redirect_valid)
            perf_redirects_q <= sat_inc(perf_redirects_q);
         if (!redirect_valid && !imem_req)
            perf_full_stalls_q <= sat_inc(perf_full_stalls_q);
      end
   end

   assign perf_fetched     = perf_fetched_q;
   assign perf_redirects   = perf_redirects_q;
   assign perf_full_stalls = perf_full_stalls_q;
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Self-checking bench: directed scenarios then random traffic against a queue-based reference model.
module tb_fetch_queue_unit;

   localparam int          DEPTH = 4;
   localparam logic [31:0] RPC   = 32'h8000_0000;
   localparam logic [31:0] KEY   = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_instr, out_pc;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched, perf_redirects, perf_full_stalls;
`endif

   fetch_queue_unit #(.XLEN(32), .RESET_PC(RPC), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_pc(out_pc)
`ifdef FETCH_PERF_EN
      , .perf_fetched(perf_fetched), .perf_redirects(perf_redirects),
      .perf_full_stalls(perf_full_stalls)
`endif
   );

   always #5 clk = ~clk;

   // Synchronous instruction memory: data depends only on the requested address.
   always @(posedge clk)
      if (imem_req) imem_rdata <= imem_addr ^ KEY;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference state: fetch PC, one outstanding request, and the queued PCs.
   logic [31:0] m_fpc;
   bit          m_infl;
   logic [31:0] m_inpc;
   logic [31:0] m_q[$];
   bit          m_known = 0;
   int          n_hs = 0;
   int          first_valid = -1;
   int          cyc = 0;
   int unsigned m_fetched = 0, m_redirs = 0, m_stalls = 0;

   task automatic step(input bit rst, input bit rv, input logic [31:0] rpc, input bit rdy);
      bit e_req, e_ov;
      @(negedge clk);
      reset = rst; redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
      #1;
      e_req = !rst && !rv && (m_q.size() + int'(m_infl) < DEPTH);
      e_ov  = !rst && !rv && (m_q.size() != 0);
      chk("imem_req", {31'b0, imem_req}, {31'b0, e_req});
      chk("out_valid", {31'b0, out_valid}, {31'b0, e_ov});
      if (!rst && m_known) chk("imem_addr", imem_addr, m_fpc);
      if (e_ov) begin
         chk("out_pc", out_pc, m_q[0]);
         chk("out_instr", out_instr, m_q[0] ^ KEY);
      end
`ifdef FETCH_PERF_EN
      if (!rst && m_known) begin
         chk("perf_fetched", perf_fetched, m_fetched);
         chk("perf_redirects", perf_redirects, m_redirs);
         chk("perf_full_stalls", perf_full_stalls, m_stalls);
      end
`endif
      @(posedge clk);
      cyc++;
      if (rst) begin
         m_fpc = RPC; m_infl = 0; m_q.delete(); m_known = 1;
         m_fetched = 0; m_redirs = 0; m_stalls = 0;
      end else if (rv) begin
         m_fpc = {rpc[31:2], 2'b00}; m_infl = 0; m_q.delete();
         m_redirs++;
      end else begin
         if (e_ov && rdy) begin void'(m_q.pop_front()); m_fetched++; n_hs++; end
         if (m_infl) m_q.push_back(m_inpc);
         if (e_req) begin m_inpc = m_fpc; m_fpc = m_fpc + 32'd4; m_infl = 1; end
         else begin m_infl = 0; m_stalls++; end
      end
   endtask

   task automatic do_reset();
      step(1, 0, '0, 0);
      step(1, 0, '0, 0);
   endtask

   initial begin
      do_reset();
      // Streaming: out_valid must first rise in cycle 2 after reset release.
      for (int i = 0; i < 20; i++) begin
         step(0, 0, '0, 1);
         if (out_valid && first_valid < 0) first_valid = i;
      end
      chk("first_valid_cycle", first_valid, 2);
      chk("stream_handshakes", n_hs, 18);
      step(0, 1, 32'h8000_0777, 1);
      // Stall then drain.
      for (int i = 0; i < 10; i++) step(0, 0, '0, 0);
      chk("stall_queue_full", m_q.size(), DEPTH);
      for (int i = 0; i < 12; i++) step(0, 0, '0, 1);
      // Redirect with 3 queued and 1 in flight.
      step(0, 1, 32'h8000_0000, 0);
      for (int i = 0; i < 4; i++) step(0, 0, '0, 0);
      chk("pre_redirect_depth", m_q.size() + m_infl, 4);
      step(0, 1, 32'h8000_0103, 1);
      for (int i = 0; i < 10; i++) step(0, 0, '0, 1);
      // Back-to-back redirects: the second target wins.
      step(0, 1, 32'h8000_0200, 1);
      step(0, 1, 32'h8000_0300, 1);
      for (int i = 0; i < 10; i++) step(0, 0, '0, 1);
      // Reset while full with a request in flight.
      for (int i = 0; i < 6; i++) step(0, 0, '0, 0);
      step(1, 0, '0, 0);
      for (int i = 0; i < 10; i++) step(0, 0, '0, 1);
      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         bit r, v, d;
         r = ($urandom_range(0, 99) == 0);
         v = ($urandom_range(0, 19) == 0);
         d = ($urandom_range(0, 3) != 0);
         step(r, v, $urandom, d);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: got %0d cycles expected completion", cyc);
      $fatal(1, "timeout");
   end

endmodule
